// File: rtl/uart_frame_tx.sv
// uart_frame_tx
// -------------
// Byte FIFO feeding an 8-bit LSB-first UART transmitter. The upstream frame
// serializer presents bytes as a level-valid strobe (drdy). Only the rising
// edge of drdy pushes a byte. Bytes leave as start / 8 data / [parity] / stop
// characters. There is no idle gap between characters while the FIFO holds
// data.
//
// Optional feature: define UART_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit, giving an 11-bit character.
// Without it the character is 10 bits long and no parity logic is built.
module uart_frame_tx #(
  parameter int BAUD_DIV   = 312,  // clock cycles per serial bit, 16..4095
  parameter int FIFO_DEPTH = 4     // byte FIFO entries, power of two, 2..16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       drdy,
  input  logic       ovf_clr,
  output logic       txd,
  output logic       busy,
  output logic       ovf
);

  localparam int             PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [11:0]    BAUD_LOAD = 12'(BAUD_DIV - 1);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity over a data byte: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  // Transmitter state
  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [11:0] baud_q, baud_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
`ifdef UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // Input edge detect and overflow flag
  logic        drdy_q;
  logic        ovf_q, ovf_d;

  // FIFO state
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Combinational helpers
  logic       push_s;
  logic       pop_s;
  logic       accept_s;
  logic       drop_s;
  logic       fifo_empty_s;
  logic       fifo_full_s;
  logic       bit_end_s;
  logic [7:0] head_s;

  assign push_s       = drdy & ~drdy_q;
  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == FIFO_FULL);
  assign head_s       = mem_q[rd_ptr_q];
  assign bit_end_s    = (baud_q == 12'd0);

  assign txd  = txd_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

  // FIFO bookkeeping: accept or drop the pushed byte, advance pointers, track the overflow flag.
  always_comb begin
    accept_s = 1'b0;
    drop_s   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    // A pop in the same cycle frees a slot, so a full FIFO still takes the byte.
    if (push_s) begin
      if (!fifo_full_s || pop_s) begin
        accept_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end

    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // A drop wins over a simultaneous clear so the loss is never hidden.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Transmitter next-state logic: bit sequencing, baud counting and FIFO pops.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    baud_d    = baud_q;
    pop_s     = 1'b0;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          baud_d  = BAUD_LOAD;
          state_d = START;
`ifdef UART_PARITY_EN
          parity_d = even_parity(head_s);
`endif
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (bit_end_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          baud_d    = BAUD_LOAD;
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end

      DATA: begin
        if (bit_end_s) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
          baud_d  = BAUD_LOAD;
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end
`endif

      STOP: begin
        if (bit_end_s) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            baud_d  = BAUD_LOAD;
            state_d = START;
`ifdef UART_PARITY_EN
            parity_d = even_parity(head_s);
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 12'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        baud_d    = 12'd0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Line level and busy flag for the next cycle, derived from the next state so both are registered.
  always_comb begin
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  // State, control and output registers; reset aborts any character and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      baud_q    <= 12'd0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drdy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      drdy_q    <= drdy;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care when the count says empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: stimulus queues expected bytes, a
// txd monitor decodes every character and checks it bit-by-bit, cycle-by-cycle.
`timescale 1ns/1ps
module tb_uart_frame_tx;
  localparam int B = 312;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CHAR = NB * B;
  localparam int PUSH_SPACING = 3301;
  localparam int GAP = (CHAR > PUSH_SPACING) ? CHAR : PUSH_SPACING;

  logic       clk = 1'b0;
  logic       rst, drdy, ovf_clr;
  logic [7:0] din;
  logic       txd, busy, ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];
  int         starts_q[$];
  logic       in_frame = 1'b0;

  logic [7:0] seq [8] = '{8'hCA, 8'h12, 8'h34, 8'h05, 8'h01, 8'h07, 8'hC8, 8'hFE};

  uart_frame_tx #(.BAUD_DIV(B), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .drdy(drdy), .ovf_clr(ovf_clr),
    .txd(txd), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chkw(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Serial frame of a byte, bit 0 = start bit.
  function automatic logic [31:0] frame_of(input logic [7:0] b);
    logic [31:0] f;
    f = 32'h0;
    f[8:1] = b;
`ifdef UART_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  task automatic pulse(input logic [7:0] b, input bit expect_tx);
    @(negedge clk);
    din  = b;
    drdy = 1'b1;
    if (expect_tx) exp_q.push_back(b);
    @(negedge clk);
    drdy = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk1("drain_done", (exp_q.size() == 0) && !in_frame, 1'b1);
  endtask

  // Monitor: detect start bits, pop the scoreboard, check every cycle of the character.
  initial begin : monitor
    logic        prev;
    logic [7:0]  eb;
    logic [31:0] ef, af;
    int          glitches;
    bit          aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else begin
        if (prev && !txd) begin
          in_frame = 1'b1;
          starts_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk1("unexpected_start", 1'b1, 1'b0);
            eb = 8'h00;
          end else begin
            eb = exp_q.pop_front();
          end
          ef = frame_of(eb);
          af = 32'h0;
          glitches = 0;
          aborted = 1'b0;
          for (int i = 0; i < NB && !aborted; i++) begin
            for (int j = 0; j < B && !aborted; j++) begin
              if (i != 0 || j != 0) @(negedge clk);
              if (rst) begin
                aborted = 1'b1;
              end else begin
                if (j == B / 2) af[i] = txd;
                if (txd !== ef[i]) glitches++;
              end
            end
          end
          if (!aborted) begin
            chkw("frame_bits", int'(af), int'(ef));
            chkw("bit_timing_errors", glitches, 0);
          end
          in_frame = 1'b0;
        end
        prev = rst ? 1'b1 : txd;
      end
    end
  end

  initial begin : stim
    int k, s, n;
    rst = 1'b1; drdy = 1'b0; din = 8'h00; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk1("reset_txd", txd, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_ovf", ovf, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x55: latency and busy duration.
    starts_q.delete();
    @(negedge clk);
    din = 8'h55; drdy = 1'b1; exp_q.push_back(8'h55);
    @(negedge clk);
    k = cyc;
    chk1("txd_high_at_push_edge", txd, 1'b1);
    chk1("busy_at_push_edge", busy, 1'b1);
    drdy = 1'b0;
    @(negedge clk);
    chk1("txd_fall_latency", txd, 1'b0);
    repeat (CHAR - 1) @(negedge clk);
    chk1("busy_before_char_end", busy, 1'b1);
    @(negedge clk);
    chk1("busy_fall_after_char", busy, 1'b0);
    chkw("start_count_55", starts_q.size(), 1);
    if (starts_q.size() > 0) chkw("start_cycle_55", starts_q[0], k + 1);
    wait_drain(100);

    // Parity-zero byte.
    pulse(8'h03, 1'b1);
    wait_drain(CHAR + 100);

    // Eight bytes, drdy held high 3300 cycles then low 1 cycle.
    starts_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      din = seq[i]; drdy = 1'b1; exp_q.push_back(seq[i]);
      repeat (PUSH_SPACING - 1) @(negedge clk);
      drdy = 1'b0;
    end
    wait_drain(3 * CHAR);
    chkw("seq_char_count", starts_q.size(), 8);
    for (int i = 1; i < starts_q.size(); i++) chkw("seq_char_spacing", starts_q[i] - starts_q[i-1], GAP);
    chk1("seq_no_ovf", ovf, 1'b0);

    // Overflow: fill during a transmission, fifth byte dropped.
    starts_q.delete();
    pulse(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    pulse(8'h11, 1'b1);
    pulse(8'h22, 1'b1);
    pulse(8'h33, 1'b1);
    pulse(8'h44, 1'b1);
    chk1("ovf_clear_when_just_full", ovf, 1'b0);
    pulse(8'h55, 1'b0);
    chk1("ovf_set_on_drop", ovf, 1'b1);
    repeat (5) @(negedge clk);
    chk1("ovf_sticky", ovf, 1'b1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk1("ovf_cleared", ovf, 1'b0);
    // Clear and drop in the same cycle: drop wins.
    @(negedge clk);
    din = 8'h77; drdy = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    drdy = 1'b0; ovf_clr = 1'b0;
    chk1("ovf_drop_beats_clear", ovf, 1'b1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk1("ovf_cleared_again", ovf, 1'b0);
    // Push on the exact edge the full FIFO pops: accepted, no overflow.
    chkw("ovf_test_first_start", starts_q.size(), 1);
    s = (starts_q.size() > 0) ? starts_q[0] : 0;
    while (cyc < s + CHAR - 1) @(negedge clk);
    din = 8'h66; drdy = 1'b1; exp_q.push_back(8'h66);
    @(negedge clk);
    drdy = 1'b0;
    chk1("push_pop_full_no_ovf", ovf, 1'b0);
    wait_drain(7 * CHAR);
    chkw("ovf_test_char_count", starts_q.size(), 6);
    for (int i = 1; i < starts_q.size(); i++) chkw("back_to_back_spacing", starts_q[i] - starts_q[i-1], CHAR);

    // Reset mid-character with two bytes queued.
    starts_q.delete();
    pulse(8'hC3, 1'b1);
    pulse(8'h5A, 1'b0);
    pulse(8'h0F, 1'b0);
    n = 0;
    while (starts_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    chkw("abort_byte_started", starts_q.size(), 1);
    s = (starts_q.size() > 0) ? starts_q[0] : cyc;
    while (cyc < s + 999) @(negedge clk);
    chk1("txd_low_before_reset", txd, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk1("reset_async_txd", txd, 1'b1);
    chk1("reset_async_busy", busy, 1'b0);
    chk1("reset_async_ovf", ovf, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (CHAR + 500) @(negedge clk);
    chkw("no_char_after_reset", starts_q.size(), 1);
    chk1("idle_after_reset", busy, 1'b0);
    chk1("txd_idle_after_reset", txd, 1'b1);

    // drdy already high at reset release counts as an edge.
    @(negedge clk);
    rst = 1'b1; din = 8'h81; drdy = 1'b1; exp_q.push_back(8'h81);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("push_after_release_busy", busy, 1'b1);
    chk1("push_after_release_txd", txd, 1'b1);
    @(negedge clk);
    chk1("push_after_release_start", txd, 1'b0);
    repeat (20) @(negedge clk);
    drdy = 1'b0;
    wait_drain(CHAR + 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
